gcd_ctrl: RTL and testbench



---
 rtl/gcd_ctrl.sv | 131 +++++++++++++
 tb/tb_gcd_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gcd_ctrl.sv
// Sequencing controller for a 16-bit subtractive GCD datapath.
// Loads A then B from data_in, then issues one conditional subtraction per cycle until eq.
module gcd_ctrl #(
   parameter int unsigned           ITER_W   = 16,
   parameter logic [ITER_W-1:0]     MAX_ITER = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              lt,
   input  logic              gt,
   input  logic              eq,
   output logic              ldA,
   output logic              ldB,
   output logic              sel1,
   output logic              sel2,
   output logic              sel_in,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [ITER_W-1:0] iter_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_ITER,
      S_DONE
   } state_t;

   state_t            r_state;
   logic              r_busy;
   logic              r_done;
   logic              r_timeout;
   logic [ITER_W-1:0] r_iter_cnt;

   logic              w_cap;
   logic              w_ldA;
   logic              w_ldB;
   logic              w_sel1;
   logic              w_sel2;
   logic              w_sel_in;

   assign w_cap = (r_iter_cnt == MAX_ITER);

   // Datapath controls are Mealy on the comparator flags during ITER.
   always_comb begin
      w_ldA    = 1'b0;
      w_ldB    = 1'b0;
      w_sel1   = 1'b0;
      w_sel2   = 1'b0;
      w_sel_in = 1'b0;
      case (r_state)
         S_LOAD_A: w_ldA = 1'b1;
         S_LOAD_B: w_ldB = 1'b1;
         S_ITER: begin
            if (!eq && !w_cap) begin
               if (gt) begin
                  w_sel1   = 1'b1;
                  w_sel_in = 1'b1;
                  w_ldA    = 1'b1;
               end else if (lt) begin
                  w_sel2   = 1'b1;
                  w_sel_in = 1'b1;
                  w_ldB    = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_timeout  <= 1'b0;
         r_iter_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_LOAD_A;
                  r_busy     <= 1'b1;
                  r_timeout  <= 1'b0;
                  r_iter_cnt <= '0;
               end
            end
            S_LOAD_A: r_state <= S_LOAD_B;
            S_LOAD_B: r_state <= S_ITER;
            S_ITER: begin
               if (eq) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else if (w_cap) begin
                  r_state   <= S_DONE;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_timeout <= 1'b1;
               end else if (gt || lt) begin
                  r_iter_cnt <= r_iter_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (start) begin
                  r_state    <= S_LOAD_A;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_timeout  <= 1'b0;
                  r_iter_cnt <= '0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ldA      = w_ldA;
   assign ldB      = w_ldB;
   assign sel1     = w_sel1;
   assign sel2     = w_sel2;
   assign sel_in   = w_sel_in;
   assign busy     = r_busy;
   assign done     = r_done;
   assign timeout  = r_timeout;
   assign iter_cnt = r_iter_cnt;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: a behavioural A/B datapath closes the loop; expected results
// are queued at start and checked by a monitor whenever done rises.
module tb_gcd_ctrl;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        lt, gt, eq;
   logic        ldA, ldB, sel1, sel2, sel_in, busy, done, timeout;
   logic [15:0] iter_cnt;

   logic [15:0] rA = '0;
   logic [15:0] rB = '0;
   logic [15:0] cur_a = '0;
   logic [15:0] cur_b = '0;
   logic [15:0] m1, m2, bus, data_in;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      int a;
      int b;
      int n;
      int to;
      int lat;
      int s;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   gcd_ctrl #(.ITER_W(16), .MAX_ITER(16'd10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .lt(lt), .gt(gt), .eq(eq),
      .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
      .busy(busy), .done(done), .timeout(timeout), .iter_cnt(iter_cnt)
   );

   // Datapath model driven by the controller
   assign m1      = sel1 ? rA : rB;
   assign m2      = sel2 ? rA : rB;
   assign data_in = ldB ? cur_b : cur_a;
   assign bus     = sel_in ? (m1 - m2) : data_in;
   assign lt      = (rA < rB);
   assign gt      = (rA > rB);
   assign eq      = (rA == rB);

   always @(posedge clk) begin
      if (ldA) rA <= bus;
      if (ldB) rB <= bus;
      cyc <= cyc + 1;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input int a, input int b, input int n, input int to, input int lat);
      exp_t e;
      e.a = a; e.b = b; e.n = n; e.to = to; e.lat = lat; e.s = cyc + 1;
      q.push_back(e);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 60; i++) begin
         if (done) return;
         @(negedge clk);
      end
      n_cmp++;
      n_bad++;
      $display("FAIL wait_done: got no done within 60 cycles, expected done");
   endtask

   task automatic run(input int a, input int b, input int ea, input int eb,
                      input int n, input int to, input int lat);
      @(negedge clk);
      cur_a = 16'(a);
      cur_b = 16'(b);
      push(ea, eb, n, to, lat);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
   endtask

   // Monitor: per-cycle control invariants plus scoreboard check on done rising
   logic prev_done = 1'b0;
   int   bcnt      = 0;
   exp_t e_mon;
   always @(negedge clk) begin
      chk("one_load", int'(ldA & ldB), 0);
      chk("selin_only_with_load", int'(sel_in & ~(ldA | ldB)), 0);
      if (!rst_n) begin
         prev_done = 1'b0;
         bcnt      = 0;
      end else begin
         if (busy) bcnt++;
         if (done && !prev_done) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: got done, expected no pending run");
            end else begin
               e_mon = q.pop_front();
               chk("result_A", int'(rA), e_mon.a);
               chk("result_B", int'(rB), e_mon.b);
               chk("iter_cnt", int'(iter_cnt), e_mon.n);
               chk("timeout", int'(timeout), e_mon.to);
               chk("done_latency", cyc - e_mon.s + 1, e_mon.lat);
               chk("busy_cycles", bcnt, e_mon.lat - 1);
               chk("done_ctrl_idle", int'({ldA, ldB, sel1, sel2, sel_in}), 0);
            end
            bcnt = 0;
         end
         prev_done = done;
      end
   end

   int ca[4] = '{48, 7, 5, 13};
   int cb[4] = '{18, 7, 0, 8};
   int ea[4] = '{6, 7, 5, 1};
   int eb[4] = '{6, 7, 0, 1};
   int en[4] = '{4, 0, 10, 5};
   int et[4] = '{0, 0, 1, 0};
   int el[4] = '{8, 4, 14, 9};
   int s_rst;

   initial begin
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ldA", int'(ldA), 0);
      chk("rst_ldB", int'(ldB), 0);
      chk("rst_sel1", int'(sel1), 0);
      chk("rst_sel2", int'(sel2), 0);
      chk("rst_sel_in", int'(sel_in), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_timeout", int'(timeout), 0);
      chk("rst_iter_cnt", int'(iter_cnt), 0);
      rst_n = 1'b1;

      run(48, 18, 6, 6, 4, 0, 8);
      run(7, 7, 7, 7, 0, 0, 4);
      run(13, 8, 1, 1, 5, 0, 9);
      run(0, 0, 0, 0, 0, 0, 4);
      run(5, 0, 5, 0, 10, 1, 14);
      run(11, 1, 1, 1, 10, 0, 14);
      run(12, 1, 2, 1, 10, 1, 14);

      // Abort in the third ITER cycle (cycle 5) of a 48/18 run
      @(negedge clk);
      cur_a = 16'd48;
      cur_b = 16'd18;
      s_rst = cyc + 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20 && cyc != s_rst + 4; i++) @(negedge clk);
      chk("pre_rst_ldB", int'(ldB), 1);
      chk("pre_rst_iter_cnt", int'(iter_cnt), 2);
      rst_n = 1'b0;
      #1;
      chk("midrun_rst_outputs",
          int'({ldA, ldB, sel1, sel2, sel_in, busy, done, timeout}), 0);
      chk("midrun_rst_iter_cnt", int'(iter_cnt), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run(48, 18, 6, 6, 4, 0, 8);

      // start held high: runs chain, each new LOAD_A straight after the DONE cycle
      @(negedge clk);
      cur_a = 16'(ca[0]);
      cur_b = 16'(cb[0]);
      push(ea[0], eb[0], en[0], et[0], el[0]);
      start = 1'b1;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         wait_done();
         cur_a = 16'(ca[k]);
         cur_b = 16'(cb[k]);
         push(ea[k], eb[k], en[k], et[k], el[k]);
      end
      @(negedge clk);
      wait_done();
      start = 1'b0;
      repeat (3) @(negedge clk);

      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL pending_runs: got %0d runs without done, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
